// File: rtl/spi_adc_responder_if.sv
// rtl/spi_adc_responder_if.sv - SPI mode-0 bus bundle between an SPI master and the ADC responder
interface spi_adc_responder_if;
   logic spi_sck;
   logic spi_cs_n;
   logic spi_mosi;
   logic spi_miso;

   modport master (output spi_sck, output spi_cs_n, output spi_mosi, input spi_miso);
   modport slave  (input spi_sck, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_adc_responder.sv
// rtl/spi_adc_responder.sv - SPI mode-0 responder returning an 8-bit channel sample per 16-bit frame
// Define SPI_RESP_FRAME_CNT_EN to build the valid-frame counter; otherwise frame_cnt is tied to zero.
module spi_adc_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   spi_adc_responder_if.slave  spi,
   input  logic [7:0]          ch0_data,
   input  logic [7:0]          ch1_data,
   output logic                frame_done,
   output logic                frame_err,
   output logic                last_ch,
   output logic [7:0]          frame_cnt
);

   typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, vld_sync;
   logic sck_prev, cs_prev, armed;
   logic sck_s, cs_s, mosi_s;
   logic sck_rise, sck_fall, cs_fall, cs_rise;

   state_t     state, state_d;
   logic [3:0] bit_cnt, bit_cnt_d;
   logic [7:0] shreg, shreg_d;
   logic       ch_sel, ch_sel_d;
   logic       miso_q, miso_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       last_ch_q, last_ch_d;

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // vld_sync marks when cs_s holds a real post-reset sample, so a cs_n that was
   // already low at reset release never looks like a fresh falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         vld_sync  <= '0;
         sck_prev  <= 1'b0;
         cs_prev   <= 1'b1;
         armed     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.spi_sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
         vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
         sck_prev  <= sck_s;
         cs_prev   <= cs_s;
         armed     <= armed | (vld_sync[SYNC_STAGES-1] & cs_s);
      end
   end

   assign sck_rise = sck_s & ~sck_prev;
   assign sck_fall = ~sck_s & sck_prev;
   assign cs_rise  = cs_s & ~cs_prev;
   assign cs_fall  = ~cs_s & cs_prev & armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= 4'd0;
         shreg     <= 8'd0;
         ch_sel    <= 1'b0;
         miso_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         last_ch_q <= 1'b0;
      end else begin
         state     <= state_d;
         bit_cnt   <= bit_cnt_d;
         shreg     <= shreg_d;
         ch_sel    <= ch_sel_d;
         miso_q    <= miso_d;
         done_q    <= done_d;
         err_q     <= err_d;
         last_ch_q <= last_ch_d;
      end
   end

   // A cs_n rise is checked before any SCK edge, so it wins a same-clk collision.
   always_comb begin
      state_d   = state;
      bit_cnt_d = bit_cnt;
      shreg_d   = shreg;
      ch_sel_d  = ch_sel;
      miso_d    = miso_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      last_ch_d = last_ch_q;
      case (state)
         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d   = CMD;
               bit_cnt_d = 4'd0;
            end
         end
         CMD: begin
            miso_d = 1'b0;
            if (cs_rise) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (sck_rise) begin
               bit_cnt_d = bit_cnt + 4'd1;
               if (bit_cnt == 4'd0 && !mosi_s) begin
                  state_d = HOLD;
                  err_d   = 1'b1;
               end
               if (bit_cnt == 4'd1) begin
                  ch_sel_d = mosi_s;
                  shreg_d  = mosi_s ? ch1_data : ch0_data;
               end
               if (bit_cnt == 4'd7)
                  state_d = DATA;
            end
         end
         DATA: begin
            if (cs_rise) begin
               state_d = IDLE;
               err_d   = 1'b1;
               miso_d  = 1'b0;
            end else if (sck_rise) begin
               bit_cnt_d = bit_cnt + 4'd1;
               if (bit_cnt == 4'd15) begin
                  state_d   = HOLD;
                  done_d    = 1'b1;
                  last_ch_d = ch_sel;
                  miso_d    = 1'b0;
               end
            end else if (sck_fall) begin
               miso_d  = shreg[7];
               shreg_d = {shreg[6:0], 1'b0};
            end
         end
         HOLD: begin
            miso_d = 1'b0;
            if (cs_rise)
               state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            miso_d  = 1'b0;
         end
      endcase
   end

   assign spi.spi_miso = miso_q;
   assign frame_done   = done_q;
   assign frame_err    = err_q;
   assign last_ch      = last_ch_q;

`ifdef SPI_RESP_FRAME_CNT_EN
   logic [7:0] frame_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         frame_cnt_q <= 8'd0;
      else if (done_d)
         frame_cnt_q <= frame_cnt_q + 8'd1;
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 8'd0;
`endif

endmodule

// File: doc/spi_adc_responder.md
SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flops in each input synchronizer (legal range 2..3).
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 spi_sck  input  1  serial clock from the SPI master; idles low (mode 0).
REQ-005 spi_cs_n  input  1  active-low frame select from the master.
REQ-006 spi_mosi  input  1  command bits from the master.
REQ-007 spi_miso  output  1  registered sample bits to the master.
REQ-008 ch0_data  input  8  channel-0 sample value (accelerator emulation).
REQ-009 ch1_data  input  8  channel-1 sample value (CDS emulation).
REQ-010 frame_done  output  1  one-clk pulse when a valid frame completes.
REQ-011 frame_err  output  1  one-clk pulse when a frame is rejected or aborted.
REQ-012 last_ch  output  1  channel served by the most recent valid frame.
REQ-013 frame_cnt  output  8  count of valid frames; wraps 255->0.

Function
REQ-014 Synchronization: spi_sck, spi_cs_n and spi_mosi each pass through SYNC_STAGES flops; edges are detected on the synchronized signals only.
REQ-015 Timing budget: supported when each SCK high and low phase is at least SYNC_STAGES+3 clk.
REQ-016 Frame format: 16 SCK rising edges, MSB first.
- MOSI bit15 = start (must be 1).
- MOSI bit14 = channel select.
- MOSI bits 13..0 are don't-care.
- MISO bits 15..8 = 0; MISO bits 7..0 = the captured sample, MSB first.
REQ-017 FSM states: IDLE, CMD, DATA, HOLD. The bit counter is 4 bits and counts synchronized rising SCK edges.
REQ-018 IDLE: a synchronized falling cs_n moves the FSM to CMD with bit counter = 0.
REQ-019 CMD, rising edge 1: MOSI is sampled as the start bit. If it is 0, pulse frame_err and go to HOLD.
REQ-020 CMD, rising edge 2: MOSI is latched as the channel. In the same clk, the selected chX_data is snapshotted into the 8-bit shift register. Later changes to chX_data do not affect the frame.
REQ-021 After rising edge 8, go to DATA. On the falling SCK edge that follows, drive shift-register bit7 on spi_miso.
REQ-022 DATA: each later falling edge shifts the next bit out. spi_miso updates exactly 1 clk after the synchronized falling edge is detected.
REQ-023 DATA, rising edge 16: pulse frame_done, set last_ch to the latched channel, increment frame_cnt, then go to HOLD.
REQ-024 HOLD: SCK edges are ignored and spi_miso = 0. A synchronized rising cs_n returns the FSM to IDLE.
REQ-025 Abort: a synchronized rising cs_n in CMD or DATA returns the FSM to IDLE within 1 clk, pulses frame_err, and sets spi_miso = 0. last_ch and frame_cnt are unchanged.
REQ-026 Simultaneous events: if a cs_n rise and an SCK edge are detected in the same clk, the cs_n rise wins and the SCK edge is discarded.
REQ-027 spi_miso is 0 whenever the FSM is not in DATA.
REQ-028 frame_done and frame_err are never asserted in the same clk.

Reset
REQ-029 rst asserted: FSM = IDLE, bit counter = 0, shift register = 0, all synchronizer flops = idle values (sck 0, cs_n 1, mosi 0).
REQ-030 rst asserted: spi_miso = 0, frame_done = 0, frame_err = 0, last_ch = 0, frame_cnt = 0.
REQ-031 Reset mid-frame discards the frame without pulsing frame_err. After reset the block waits for a fresh cs_n falling edge; a cs_n already low at reset release does not start a frame.

Configuration
REQ-032 Macro SPI_RESP_FRAME_CNT_EN defined: frame_cnt behaves as REQ-023 and REQ-030.
REQ-033 Macro SPI_RESP_FRAME_CNT_EN undefined: no counter register is built and frame_cnt is tied to 8'd0. All other behaviour is identical.

Verification
REQ-034 ch0_data=8'hA5, MOSI cmd 8'b10xxxxxx, SCK half-period 8 clk -> master reads 8'hA5; frame_done pulses once; last_ch=0; frame_cnt=1.
REQ-035 ch1_data=8'h3C, cmd 8'b11xxxxxx; ch1_data changes to 8'hFF after rising edge 3 -> master reads 8'h3C; last_ch=1.
REQ-036 cmd start bit 0 -> frame_err pulses 1 clk after rising edge 1; MISO stays 0 for the whole frame; frame_cnt is unchanged.
REQ-037 cs_n deasserted after rising edge 11 -> frame_err pulses; no frame_done; the next full frame with ch0_data=8'h01 reads 8'h01.
REQ-038 256 valid frames -> frame_cnt wraps to 0; with SPI_RESP_FRAME_CNT_EN undefined, frame_cnt stays 0 throughout.
REQ-039 rst pulsed during DATA -> spi_miso=0 next clk; no pulse on frame_err or frame_done; the next frame completes normally.
